// File: rtl/iter_shifter.sv
// Multi-cycle shift unit (SLL/SRL/SRA/ROR), shifting at most STEP bits per clock.
// Define ITER_SHIFTER_ROTATE_EN to build the rotate path; otherwise op 11 acts as SRL.
//
// state | meaning
// IDLE  | ready for a request
// RUN   | shifting acc, up to STEP bits per cycle, until rem is 0
// DONE  | result held on data_out until out_ready
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 op,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic                       busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP_K = (SHW+1)'(STEP);
`ifdef ITER_SHIFTER_ROTATE_EN
  localparam logic [SHW:0] WIDTH_K = (SHW+1)'(WIDTH);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc, acc_step, dout;
  logic [SHW-1:0]   rem;
  logic [SHW:0]     rem_ext, k;
  logic             last_step;

  // rem is always below WIDTH, so k never reaches WIDTH and the rotate
  // complement shift (WIDTH - k) stays in range.
  assign rem_ext   = {1'b0, rem};
  assign k         = (rem_ext < STEP_K) ? rem_ext : STEP_K;
  assign last_step = (rem_ext == k);

  always_comb begin
    acc_step = acc >> k;
    case (op_q)
      2'b00: acc_step = acc << k;
      2'b10: acc_step = $unsigned($signed(acc) >>> k);
`ifdef ITER_SHIFTER_ROTATE_EN
      2'b11: acc_step = (acc >> k) | (acc << (WIDTH_K - k));
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (in_valid) state_d = (shamt == '0) ? DONE : RUN;
      RUN:  if (last_step) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // dout is a separate register so a new accept cannot disturb the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      acc  <= '0;
      rem  <= '0;
      dout <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= op;
            acc  <= data_in;
            rem  <= shamt;
            if (shamt == '0) dout <= data_in;
          end
        end
        RUN: begin
          acc <= acc_step;
          rem <= rem - k[SHW-1:0];
          if (last_step) dout <= acc_step;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign data_out  = dout;

endmodule
